// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encoding and FSM state encoding shared by the multiply/divide unit.
package muldiv_pkg;
  localparam logic [2:0] MULT  = 3'd0;
  localparam logic [2:0] MULTU = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] DIVU  = 3'd3;
  localparam logic [2:0] MTHI  = 3'd4;
  localparam logic [2:0] MTLO  = 3'd5;
  localparam logic [2:0] MADD  = 3'd6;
  localparam logic [2:0] MSUB  = 3'd7;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: combinational {res_hi,res_lo} for op on src_a/src_b and current {hi,lo}; ports op, src_a, src_b, hi, lo in, res_hi, res_lo out. MULDIV_MADD_EN enables the accumulate path.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  logic [2*WIDTH-1:0] sprod, uprod;
  logic [WIDTH-1:0] dvs, sq, sr, uq, ur;
  logic dz, ovf;
  assign sprod = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
  assign uprod = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
  assign dz = src_b == '0;
  assign ovf = op == DIV && src_a == {1'b1, {(WIDTH-1){1'b0}}} && &src_b;
  // Corner cases are muxed below; a benign divisor keeps the dividers defined.
  assign dvs = (dz | ovf) ? WIDTH'(1) : src_b;
  assign sq = $signed(src_a) / $signed(dvs);
  assign sr = $signed(src_a) % $signed(dvs);
  assign uq = src_a / dvs;
  assign ur = src_a % dvs;
  always_comb begin
    {res_hi, res_lo} = {hi, lo};
    if (op == MULT) {res_hi, res_lo} = sprod;
    if (op == MULTU) {res_hi, res_lo} = uprod;
    if (op == DIV || op == DIVU)
      {res_hi, res_lo} = dz ? {src_a, {WIDTH{1'b1}}} : ovf ? {{WIDTH{1'b0}}, src_a} : op == DIV ? {sr, sq} : {ur, uq};
`ifdef MULDIV_MADD_EN
    if (op == MADD) {res_hi, res_lo} = {hi, lo} + sprod;
    if (op == MSUB) {res_hi, res_lo} = {hi, lo} - sprod;
`endif
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit owning HI/LO; ports clk, reset, start, op, src_a, src_b, cancel in, busy, hi, lo out. MULDIV_MADD_EN enables MADD/MSUB (otherwise they are no-ops).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t state, next;
  logic [7:0] cnt, lat;
  logic [WIDTH-1:0] pend_hi, pend_lo, res_hi, res_lo;
  logic accept, long_op, done;
  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .op(op), .src_a(src_a), .src_b(src_b), .hi(hi), .lo(lo), .res_hi(res_hi), .res_lo(res_lo)
  );
  assign accept = start & ~cancel & ~busy;
`ifdef MULDIV_MADD_EN
  assign long_op = op != MTHI && op != MTLO;
`else
  assign long_op = op inside {MULT, MULTU, DIV, DIVU};
`endif
  assign lat = (op == DIV || op == DIVU) ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
  assign done = state == BUSY && cnt == 8'd1;
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  always_comb
    next = state == IDLE ? ((accept && long_op) ? BUSY : IDLE) : (done ? IDLE : BUSY);
  always_comb
    busy = state == BUSY;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (accept && long_op) begin
        cnt <= lat;
        pend_hi <= res_hi;
        pend_lo <= res_lo;
      end else if (state == BUSY) cnt <= cnt - 8'd1;
      if (done) {hi, lo} <= {pend_hi, pend_lo};
      if (accept && op == MTHI) hi <= src_a;
      if (accept && op == MTLO) lo <= src_a;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit at default parameters.
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic clk = 0, reset = 1, start = 0, cancel = 0, busy;
  logic [2:0] op = MULT;
  logic [31:0] src_a = 0, src_b = 0, hi, lo;
  int n_cmp = 0, n_bad = 0;
  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) assert (!(start && busy)) else $error("start while busy");
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic can_mid, input int cyc, input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] oh, ol;
    int n;
    logic held;
    oh = hi;
    ol = lo;
    @(negedge clk);
    start = 1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 0;
    n = 0;
    held = 1;
    while (busy && n < 300) begin
      if (hi !== oh || lo !== ol) held = 0;
      if (can_mid && n == 1) cancel = 1;
      n++;
      @(negedge clk);
    end
    cancel = 0;
    chk({tag, " cycles"}, 64'(n), 64'(cyc));
    chk({tag, " held"}, 64'(held), 64'd1);
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    run_op("mult", MULT, 32'hFFFFFFFE, 32'd3, 0, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("div", DIV, 32'hFFFFFFF9, 32'd2, 0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_neg_b", DIV, 32'd7, 32'hFFFFFFFE, 0, 10, 32'd1, 32'hFFFFFFFD);
    run_op("divu", DIVU, 32'd100, 32'd7, 0, 10, 32'd2, 32'd14);
    run_op("divu_z", DIVU, 32'd7, 32'd0, 0, 10, 32'd7, 32'hFFFFFFFF);
    run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 0, 10, 32'd0, 32'h80000000);
    run_op("divu_big", DIVU, 32'h80000000, 32'hFFFFFFFF, 0, 10, 32'h80000000, 32'd0);
    run_op("mthi", MTHI, 32'h1234, 32'd0, 0, 0, 32'h1234, 32'h00000000);
    run_op("mtlo", MTLO, 32'h5678, 32'd0, 0, 0, 32'h1234, 32'h5678);
`ifdef MULDIV_MADD_EN
    run_op("madd", MADD, 32'd2, 32'd3, 0, 5, 32'h1234, 32'h567E);
    run_op("msub", MSUB, 32'd1, 32'd7, 0, 5, 32'h1234, 32'h5677);
    run_op("msub_neg", MSUB, 32'hFFFFFFFF, 32'h5677, 0, 5, 32'h1234, 32'hACEE);
`else
    run_op("madd", MADD, 32'd2, 32'd3, 0, 0, 32'h1234, 32'h5678);
    run_op("msub", MSUB, 32'd1, 32'd7, 0, 0, 32'h1234, 32'h5678);
`endif
    @(negedge clk);
    start = 1; cancel = 1; op = MULT; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    chk("cancel busy", 64'(busy), 64'd0);
    op = MTHI;
    @(negedge clk);
    start = 0; cancel = 0;
    chk("cancel busy2", 64'(busy), 64'd0);
    chk("cancel hilo", {hi, lo}, 64'h00001234_00000000 | 64'(lo));
    chk("cancel hi", 64'(hi), 64'h1234);
    run_op("cancel_mid", MULTU, 32'd3, 32'd4, 1, 5, 32'd0, 32'd12);
    @(negedge clk);
    start = 1; op = MULT; src_a = 32'd5; src_b = 32'd5;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid busy3", 64'(busy), 64'd1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_mid busy", 64'(busy), 64'd0);
    chk("rst_mid hi", 64'(hi), 64'd0);
    chk("rst_mid lo", 64'(lo), 64'd0);
    run_op("multu", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 5, 32'hFFFFFFFE, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
